// File: rtl/uart_pkg.sv
// Shared frame constants and engine state encodings for the baud_uart console port.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/baud_uart_tick.sv
// Fractional bit-rate accumulator: adds baud (or 2*baud in half-bit mode) every clk
// and fires tick_o on the cycle the running sum reaches CLKFREQ.
module baud_tick #(
  parameter int unsigned CLKFREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [31:0] baud_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        half_i,
  output logic        tick_o
);

  localparam logic [33:0] MOD   = 34'(CLKFREQ);
  localparam logic [31:0] MOD32 = 32'(CLKFREQ);

  logic [31:0] acc_q, acc_d;
  logic [32:0] step;
  logic [33:0] sum;

  always_comb begin
    step   = half_i ? {baud_i, 1'b0} : {1'b0, baud_i};
    sum    = {2'b00, acc_q} + {1'b0, step};
    tick_o = 1'b0;
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      // keeping the residue after a wrap is what makes the mean period exact
      if (sum >= MOD) begin
        tick_o = 1'b1;
        acc_d  = sum[31:0] - MOD32;
      end else begin
        acc_d = sum[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_uart.sv
// Full-duplex 8N1 console UART with run-time baud; one baud_tick per engine.
// States: IDLE line idle | START start bit (RX: half-bit wait) | DATA 8 data bits | STOP stop bit.
module baud_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLKFREQ = 50_000_000
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic [31:0]          baud,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 rd,
  input  logic                 wr,
  output logic                 valid,
  output logic                 busy,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic [DATA_BITS-1:0] rx_data
);

  tx_state_e              tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic                   tx_q, tx_d;
  logic                   tx_tick;

  rx_state_e              rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  logic                   rx_tick, rx_got;

  baud_tick #(.CLKFREQ(CLKFREQ)) u_tx_tick (
    .clk    (clk),
    .resetq (resetq),
    .baud_i (baud),
    .en_i   (tx_state_q != TX_IDLE),
    .clr_i  (tx_state_q == TX_IDLE),
    .half_i (1'b0),
    .tick_o (tx_tick)
  );

  baud_tick #(.CLKFREQ(CLKFREQ)) u_rx_tick (
    .clk    (clk),
    .resetq (resetq),
    .baud_i (baud),
    .en_i   (rx_state_q != RX_IDLE),
    .clr_i  (rx_state_q == RX_IDLE),
    .half_i (rx_state_q == RX_START),
    .tick_o (rx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TX_IDLE: if (wr) begin
        tx_state_d = TX_START;
        tx_sh_d    = tx_data;
        tx_cnt_d   = '0;
        tx_d       = 1'b0;
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_d       = tx_sh_q[0];
        tx_sh_d    = tx_sh_q >> 1;
      end
      TX_DATA: if (tx_tick) begin
        if (tx_cnt_q == CNT_W'(DATA_BITS - 1)) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_d     = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // A start needs a high-to-low edge, so a line stuck low after a bad stop cannot re-arm.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    rx_got     = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      RX_START: if (rx_tick) begin
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_cnt_q == CNT_W'(DATA_BITS - 1)) rx_state_d = RX_STOP;
        else                                   rx_cnt_d   = rx_cnt_q + CNT_W'(1);
      end
      RX_STOP: if (rx_tick) begin
        rx_state_d = RX_IDLE;
        if (rx_s2_q) begin
          rx_data_d = rx_sh_q;
          rx_got    = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    valid_d = valid_q;
    if (rd)     valid_d = 1'b0;
    if (rx_got) valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_sh_q    <= rx_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = (tx_state_q != TX_IDLE);
  assign valid   = valid_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_baud_uart.sv
// Scoreboard bench for baud_uart at CLKFREQ=1 MHz: 100 kbaud for framing, 33333 baud for jitter.
module tb_baud_uart;

  localparam int unsigned CLKFREQ = 1_000_000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic [31:0] baud = 32'd100_000;
  logic [7:0]  tx_data = 8'h00;
  logic        tx, valid, busy, rx_in;
  logic [7:0]  rx_data;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, evt_cyc = 0;
  logic [7:0]  sb[$];
  int          edges[$];
  logic        pv = 1'b0;
  logic [7:0]  pd = 8'h00;

  assign rx_in = loop ? tx : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baud_uart #(.CLKFREQ(CLKFREQ)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .baud    (baud),
    .rx      (rx_in),
    .tx      (tx),
    .rd      (rd),
    .wr      (wr),
    .valid   (valid),
    .busy    (busy),
    .tx_data (tx_data),
    .rx_data (rx_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Received bytes show up as valid rising or rx_data changing while valid (overrun).
  always @(negedge clk) begin
    if (valid === 1'b1 && (!pv || rx_data !== pd)) begin
      evt_cyc = cyc;
      chk("rx_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("rx_byte", 32'(rx_data), 32'(sb.pop_front()));
    end
    pv = valid;
    pd = rx_data;
  end

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; tx_data = b;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_drv = f[i];
      repeat (9) @(negedge clk);
    end
    @(negedge clk); rx_drv = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_sb(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin @(negedge clk); n++; end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_tx_idle(input int max);
    int n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    chk("tx_done", 32'(busy), 32'd0);
  endtask

  task automatic measure(input logic [7:0] b, output int len);
    logic p;
    edges.delete();
    len = -1;
    send_tx(b);
    p = tx;
    for (int i = 1; i < 400 && len < 0; i++) begin
      @(negedge clk);
      if (tx !== p) edges.push_back(i);
      p = tx;
      if (!busy) len = i;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         fall, lat, len;
    logic [9:0] fr;
    real        per, d;

    repeat (3) @(negedge clk);
    resetq = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle", 32'({tx, busy, valid, rx_data}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    end

    fr = {1'b1, 8'h55, 1'b0};
    send_tx(8'h55);
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      chk("tx55_bit", 32'(tx), 32'(fr[i / 10]));
      chk("tx55_busy", 32'(busy), 32'd1);
      if (i == 50) begin wr = 1'b1; tx_data = 8'hFF; end
      if (i == 51) wr = 1'b0;
    end
    @(negedge clk);
    chk("tx55_busy_end", 32'(busy), 32'd0);
    chk("tx55_line_idle", 32'(tx), 32'd1);

    loop = 1'b1;
    @(negedge clk);
    sb.push_back(8'hA3);
    send_tx(8'hA3);
    fall = cyc;
    wait_sb(200);
    lat = evt_cyc - fall;
    chk("lb_latency_90_105", 32'(lat >= 90 && lat <= 105), 32'd1);
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    chk("lb_rd_clears", 32'(valid), 32'd0);
    wait_tx_idle(200);
    loop = 1'b0;

    sb.push_back(8'h3C); send_rx(8'h3C, 1'b1);
    sb.push_back(8'hC3); send_rx(8'hC3, 1'b1);
    wait_sb(50);
    chk("ovr_valid", 32'(valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h0000_00C3);
    send_rx(8'h77, 1'b0);
    chk("ferr_data", 32'(rx_data), 32'h0000_00C3);
    chk("ferr_valid", 32'(valid), 32'd1);
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    chk("rd_clears", 32'(valid), 32'd0);

    @(negedge clk); rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_no_valid", 32'(valid), 32'd0);
    sb.push_back(8'h12); send_rx(8'h12, 1'b1);
    wait_sb(50);
    chk("post_glitch_data", 32'(rx_data), 32'h0000_0012);

    send_tx(8'h00);
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    resetq = 1'b0;
    #1;
    chk("rst_abort", 32'({tx, busy, valid, rx_data}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clk); resetq = 1'b1;
    @(negedge clk);

    baud = 32'd33_333;
    per  = real'(CLKFREQ) / real'(baud);
    @(negedge clk);
    measure(8'h55, len);
    chk("b33_55_edges", 32'(edges.size()), 32'd9);
    for (int k = 0; k < edges.size(); k++) begin
      d = real'(edges[k]) - real'(k + 1) * per;
      chk("b33_55_edge_pos", 32'(d <= 1.0 && d >= -1.0), 32'd1);
    end
    d = real'(len) - 10.0 * per;
    chk("b33_55_frame_len", 32'(d <= 1.0 && d >= -1.0), 32'd1);

    repeat (5) @(negedge clk);
    measure(8'h00, len);
    chk("b33_00_edges", 32'(edges.size()), 32'd1);
    if (edges.size() == 1) begin
      d = real'(edges[0]) - 9.0 * per;
      chk("b33_00_stop_edge", 32'(d <= 1.0 && d >= -1.0), 32'd1);
    end
    d = real'(len) - 10.0 * per;
    chk("b33_00_frame_len", 32'(d <= 1.0 && d >= -1.0), 32'd1);
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
